// File: rtl/wash_pkg.sv
// Shared types for the wash program sequencer: state encoding and the
// per-state output decode used by the sequencer's registered outputs.
package wash_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'd0,
        LOCK  = 4'd1,
        FILL  = 4'd2,
        DET   = 4'd3,
        WASH  = 4'd4,
        RINSE = 4'd5,
        DRAIN = 4'd6,
        SPIN  = 4'd7,
        DONE  = 4'd8,
        FAULT = 4'd9
    } state_t;

    typedef struct packed {
        logic door_lock;
        logic fill_valve_on;
        logic motor_on;
        logic spin_on;
        logic drain_valve_on;
        logic done;
        logic fault;
    } outs_t;

    // Motor and spin are decoded as "on" here; pause gating happens at the port.
    function automatic outs_t decode_state(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            LOCK:  o.door_lock = 1'b1;
            FILL:  begin o.door_lock = 1'b1; o.fill_valve_on = 1'b1; end
            DET:   o.door_lock = 1'b1;
            WASH:  begin o.door_lock = 1'b1; o.motor_on = 1'b1; end
            RINSE: begin o.door_lock = 1'b1; o.motor_on = 1'b1; end
            DRAIN: begin o.door_lock = 1'b1; o.drain_valve_on = 1'b1; end
            SPIN:  begin o.door_lock = 1'b1; o.drain_valve_on = 1'b1; o.spin_on = 1'b1; end
            DONE:  o.done = 1'b1;
            FAULT: begin o.door_lock = 1'b1; o.drain_valve_on = 1'b1; o.fault = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/wash_program_sequencer_if.sv
// Front-panel/sensor inputs and valve/motor outputs of the wash sequencer.
interface wash_program_sequencer_if;
    import wash_pkg::*;

    logic               start;
    logic               door_close;
    logic               water_filled;
    logic               drained;
    logic               detergent_added;
    logic [1:0]         rinses;
    logic               pause;
    logic               clear_fault;
    logic               door_lock;
    logic               fill_valve_on;
    logic               motor_on;
    logic               spin_on;
    logic               drain_valve_on;
    logic               done;
    logic               fault;
    logic [STATE_W-1:0] state_o;

    modport master (
        output start, door_close, water_filled, drained, detergent_added,
               rinses, pause, clear_fault,
        input  door_lock, fill_valve_on, motor_on, spin_on, drain_valve_on,
               done, fault, state_o
    );

    modport slave (
        input  start, door_close, water_filled, drained, detergent_added,
               rinses, pause, clear_fault,
        output door_lock, fill_valve_on, motor_on, spin_on, drain_valve_on,
               done, fault, state_o
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Saturating phase timer: cleared on state entry, frozen while hold is high.
module wash_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (!hold && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/wash_program_sequencer.sv
// Washing machine program sequencer: lock, fill, detergent, wash, drain,
// N rinse cycles, spin, done; watchdogs fill/drain and faults on door open.
module wash_program_sequencer
    import wash_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WASH_TICKS  = 100,
    parameter int RINSE_TICKS = 60,
    parameter int SPIN_TICKS  = 80,
    parameter int FILL_LIMIT  = 200,
    parameter int DRAIN_LIMIT = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    wash_program_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] L_WASH_END  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] L_RINSE_END = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] L_SPIN_END  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] L_FILL_END  = CNT_W'(FILL_LIMIT - 1);
    localparam logic [CNT_W-1:0] L_DRAIN_END = CNT_W'(DRAIN_LIMIT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_rinse_cnt;
    logic [1:0]       r_rinse_tgt;
    outs_t            r_outs;
    logic [CNT_W-1:0] w_count;
    logic             w_agitating;
    logic             w_hold;
    logic             w_clr;
    logic             w_door_guarded;

    assign w_agitating    = (r_state == WASH) || (r_state == RINSE) || (r_state == SPIN);
    assign w_hold         = w_agitating && bus.pause;
    assign w_clr          = (w_state_next != r_state);
    assign w_door_guarded = (r_state == LOCK) || (r_state == FILL) || (r_state == DET) ||
                            (r_state == WASH) || (r_state == RINSE) || (r_state == DRAIN) ||
                            (r_state == SPIN);

    wash_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .hold  (w_hold),
        .count (w_count)
    );

    // An open door outranks every other transition while the drum may hold water.
    always_comb begin
        w_state_next = r_state;
        if (w_door_guarded && !bus.door_close) begin
            w_state_next = FAULT;
        end else begin
            case (r_state)
                IDLE:  if (bus.start && bus.door_close) w_state_next = LOCK;
                LOCK:  w_state_next = FILL;
                FILL: begin
                    if (bus.water_filled)
                        w_state_next = (r_rinse_cnt == 2'd0) ? DET : RINSE;
                    else if (w_count == L_FILL_END)
                        w_state_next = FAULT;
                end
                DET:   if (bus.detergent_added) w_state_next = WASH;
                WASH:  if (w_count == L_WASH_END && !bus.pause) w_state_next = DRAIN;
                RINSE: if (w_count == L_RINSE_END && !bus.pause) w_state_next = DRAIN;
                DRAIN: begin
                    if (bus.drained)
                        w_state_next = (r_rinse_cnt < r_rinse_tgt) ? FILL : SPIN;
                    else if (w_count == L_DRAIN_END)
                        w_state_next = FAULT;
                end
                SPIN:  if (w_count == L_SPIN_END && !bus.pause) w_state_next = DONE;
                DONE:  w_state_next = IDLE;
                FAULT: if (bus.clear_fault && bus.drained) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rinse_cnt <= 2'd0;
            r_rinse_tgt <= 2'd0;
            r_outs      <= '0;
        end else begin
            r_state <= w_state_next;
            r_outs  <= decode_state(w_state_next);
            if (r_state == IDLE && w_state_next == LOCK) begin
                r_rinse_tgt <= bus.rinses;
                r_rinse_cnt <= 2'd0;
            end else if (r_state == DRAIN && w_state_next == FILL) begin
                r_rinse_cnt <= r_rinse_cnt + 2'd1;
            end
        end
    end

    assign bus.door_lock      = r_outs.door_lock;
    assign bus.fill_valve_on  = r_outs.fill_valve_on;
    assign bus.motor_on       = r_outs.motor_on && !bus.pause;
    assign bus.spin_on        = r_outs.spin_on && !bus.pause;
    assign bus.drain_valve_on = r_outs.drain_valve_on;
    assign bus.done           = r_outs.done;
    assign bus.fault          = r_outs.fault;
    assign bus.state_o        = r_state;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Bench for wash_program_sequencer: directed program scenarios plus random
// stimulus, all checked cycle by cycle against a phase-list reference model.
module tb_wash_program_sequencer;
    import wash_pkg::*;

    localparam int W_T = 4, R_T = 3, S_T = 5, F_LIM = 8, D_LIM = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wash_program_sequencer_if bus();

    wash_program_sequencer #(
        .CNT_W(16), .WASH_TICKS(W_T), .RINSE_TICKS(R_T), .SPIN_TICKS(S_T),
        .FILL_LIMIT(F_LIM), .DRAIN_LIMIT(D_LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the program is a list of phases built at start time.
    int m_state = 0;
    int m_t     = 0;
    int m_plan[$];
    int m_idx   = 0;

    function automatic logic [6:0] exp_outs(input int st, input logic p);
        // {door_lock, fill, motor, spin, drain, done, fault}
        case (st)
            1, 3:    return 7'b1000000;
            2:       return 7'b1100000;
            4, 5:    return {1'b1, 1'b0, !p, 4'b0000};
            6:       return 7'b1000100;
            7:       return {1'b1, 2'b00, !p, 1'b1, 2'b00};
            8:       return 7'b0000010;
            9:       return 7'b1000101;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_step();
        int  nxt;
        bit  adv;
        nxt = m_state;
        adv = 1'b0;
        if (m_state == 0) begin
            if (bus.start && bus.door_close) begin
                m_plan.delete();
                m_plan.push_back(1); m_plan.push_back(2); m_plan.push_back(3);
                m_plan.push_back(4); m_plan.push_back(6);
                for (int k = 0; k < int'(bus.rinses); k++) begin
                    m_plan.push_back(2); m_plan.push_back(5); m_plan.push_back(6);
                end
                m_plan.push_back(7); m_plan.push_back(8);
                m_idx = 0;
                nxt = m_plan[0];
            end
        end else if (m_state >= 1 && m_state <= 7 && !bus.door_close) begin
            nxt = 9;
        end else begin
            case (m_state)
                1: adv = 1'b1;
                2: if (bus.water_filled) adv = 1'b1; else if (m_t == F_LIM - 1) nxt = 9;
                3: adv = bus.detergent_added;
                4: adv = (m_t == W_T - 1) && !bus.pause;
                5: adv = (m_t == R_T - 1) && !bus.pause;
                6: if (bus.drained) adv = 1'b1; else if (m_t == D_LIM - 1) nxt = 9;
                7: adv = (m_t == S_T - 1) && !bus.pause;
                8: nxt = 0;
                9: if (bus.clear_fault && bus.drained) nxt = 0;
                default: nxt = 0;
            endcase
        end
        if (adv) begin
            m_idx++;
            nxt = m_plan[m_idx];
        end
        if (nxt != m_state) m_t = 0;
        else if (!(bus.pause && (m_state == 4 || m_state == 5 || m_state == 7))) m_t++;
        m_state = nxt;
    endtask

    int obs_motor, obs_spin, obs_done, obs_fill_entries, obs_wash, obs_fill_cycles;
    int prev_state;

    task automatic clear_obs();
        obs_motor = 0; obs_spin = 0; obs_done = 0;
        obs_fill_entries = 0; obs_wash = 0; obs_fill_cycles = 0;
        prev_state = int'(bus.state_o);
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        logic [6:0] got;
        #1;
        got = {bus.door_lock, bus.fill_valve_on, bus.motor_on, bus.spin_on,
               bus.drain_valve_on, bus.done, bus.fault};
        check_val("state_o", int'(bus.state_o), m_state);
        check_val("outputs", int'(got), int'(exp_outs(m_state, bus.pause)));
        obs_motor += int'(bus.motor_on);
        obs_spin  += int'(bus.spin_on);
        obs_done  += int'(bus.done);
        if (bus.state_o == 4'd4) obs_wash++;
        if (bus.state_o == 4'd2) obs_fill_cycles++;
        if (bus.state_o == 4'd2 && prev_state != 2) obs_fill_entries++;
        prev_state = int'(bus.state_o);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle_inputs();
        bus.start = 1'b0; bus.door_close = 1'b1; bus.water_filled = 1'b0;
        bus.drained = 1'b0; bus.detergent_added = 1'b0; bus.rinses = 2'd0;
        bus.pause = 1'b0; bus.clear_fault = 1'b0;
    endtask

    // Drives a cooperative program; stops at program end or when the model reaches stop_at.
    task automatic run_prog(input int rinses, input int pause_len, input int stop_at, input bit fill_ok);
        bit started;
        int pcnt;
        int guard;
        started = 1'b0;
        pcnt = 0;
        guard = 300;
        clear_obs();
        while (guard > 0) begin
            guard--;
            if (stop_at >= 0 && m_state == stop_at) break;
            bus.start           = (m_state == 0) && !started;
            bus.door_close      = 1'b1;
            bus.rinses          = 2'(rinses);
            bus.water_filled    = fill_ok && (m_state == 2) && (m_t >= 1);
            bus.detergent_added = (m_state == 3);
            bus.drained         = (m_state == 6) && (m_t >= 1);
            bus.clear_fault     = 1'b0;
            bus.pause           = (m_state == 4) && (m_t == 1) && (pcnt < pause_len);
            if (bus.pause) pcnt++;
            tick();
            if (m_state != 0) started = 1'b1;
            else if (started) break;
        end
        if (guard == 0) check_val("run_budget", guard, 1);
        set_idle_inputs();
    endtask

    initial begin
        set_idle_inputs();
        @(negedge clk);
        #1;
        check_val("reset_state", int'(bus.state_o), 0);
        check_val("reset_outs", int'({bus.door_lock, bus.fill_valve_on, bus.motor_on,
                  bus.spin_on, bus.drain_valve_on, bus.done, bus.fault}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal program, no rinses
        run_prog(0, 0, -1, 1'b1);
        check_val("r0_motor_cycles", obs_motor, W_T);
        check_val("r0_spin_cycles", obs_spin, S_T);
        check_val("r0_done_pulses", obs_done, 1);
        check_val("r0_fill_entries", obs_fill_entries, 1);
        #1 check_val("r0_back_idle", int'(bus.state_o), 0);
        tick();

        // Two rinses
        run_prog(2, 0, -1, 1'b1);
        check_val("r2_fill_entries", obs_fill_entries, 3);
        check_val("r2_motor_cycles", obs_motor, W_T + 2 * R_T);
        check_val("r2_spin_cycles", obs_spin, S_T);
        check_val("r2_done_pulses", obs_done, 1);

        // Pause for two cycles mid-wash
        run_prog(0, 2, -1, 1'b1);
        check_val("pause_wash_cycles", obs_wash, W_T + 2);
        check_val("pause_motor_cycles", obs_motor, W_T);

        // Fill watchdog
        run_prog(0, 0, 9, 1'b0);
        check_val("fill_timeout_cycles", obs_fill_cycles, F_LIM);
        #1;
        check_val("fault_flag", int'(bus.fault), 1);
        check_val("fault_drain_valve", int'(bus.drain_valve_on), 1);
        bus.clear_fault = 1'b1;
        bus.drained = 1'b0;
        tick();
        tick();
        #1 check_val("fault_holds_wet", int'(bus.state_o), 9);
        bus.drained = 1'b1;
        tick();
        #1;
        check_val("fault_cleared_state", int'(bus.state_o), 0);
        check_val("fault_cleared_outs", int'({bus.door_lock, bus.drain_valve_on, bus.fault}), 0);
        set_idle_inputs();
        tick();

        // Door opened during spin
        run_prog(0, 0, 7, 1'b1);
        bus.door_close = 1'b0;
        tick();
        #1;
        check_val("door_spin_fault", int'(bus.state_o), 9);
        check_val("door_spin_spin_off", int'(bus.spin_on), 0);
        check_val("door_spin_lock", int'(bus.door_lock), 1);
        bus.door_close = 1'b1;
        bus.clear_fault = 1'b1;
        bus.drained = 1'b1;
        tick();
        set_idle_inputs();
        tick();

        // Asynchronous reset mid-rinse
        run_prog(1, 0, 5, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_state", int'(bus.state_o), 0);
        check_val("async_rst_outs", int'({bus.door_lock, bus.fill_valve_on, bus.motor_on,
                  bus.spin_on, bus.drain_valve_on, bus.done, bus.fault}), 0);
        m_state = 0;
        m_t = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_prog(1, 0, -1, 1'b1);
        check_val("post_rst_done", obs_done, 1);
        check_val("post_rst_fill_entries", obs_fill_entries, 2);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start           = ($urandom_range(99) < 50);
            bus.door_close      = ($urandom_range(99) >= 2);
            bus.water_filled    = ($urandom_range(99) < 30);
            bus.drained         = ($urandom_range(99) < 30);
            bus.detergent_added = ($urandom_range(99) < 40);
            bus.rinses          = 2'($urandom_range(3));
            bus.pause           = ($urandom_range(99) < 20);
            bus.clear_fault     = ($urandom_range(99) < 30);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
